load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage (ALU effective address, funct3, rs2 data) and the 64-bit data memory.
- Translates RV64 byte-addressed loads and stores (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) into doubleword-wide accesses.
- The data memory only writes whole 64-bit words, so sub-doubleword stores are done by this block as a read-merge-write sequence.
- Returns sign- or zero-extended load data to writeback through a valid/ready handshake.

Parameters:
- ADDR_W, 64, width of the incoming byte address.
- MEM_ADDR_W, 16, width of the doubleword index sent to data memory.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  execute stage presents a memory operation.
- req_ready  output  1  block can accept a request.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (size and signedness).
- req_addr  input  ADDR_W  byte effective address.
- req_wdata  input  64  store data (rs2), right-aligned.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  writeback accepts the response.
- rsp_rdata  output  64  extended load data; 0 for stores.
- rsp_error  output  1  misaligned access; no memory side effect.
- mem_access_addr  output  MEM_ADDR_W  doubleword index, equal to addr[MEM_ADDR_W+2:3].
- mem_write_data  output  64  full doubleword to write.
- mem_write_en  output  1  write strobe, sampled at the memory's clk edge.
- mem_read  output  1  read qualifier.
- mem_read_data  input  64  combinational read data for mem_access_addr.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - FSM = IDLE.
  - req_ready=1; rsp_valid=0; rsp_error=0; rsp_rdata=0.
  - mem_write_en=0; mem_read=0; mem_access_addr=0; mem_write_data=0.
- Reset mid-operation aborts the operation. Any pending WRITE is dropped: mem_write_en is decoded from state, so it deasserts immediately.
- States: IDLE, ACCESS, WRITE, RESP. req_ready=1 only in IDLE.
- IDLE:
  - On req_valid, latch is_store, funct3, addr and wdata.
  - Misaligned request (half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0): set rsp_error=1 and go to RESP. No memory access.
  - Illegal funct3 (load 3'b111, store funct3[2]=1): treated as misaligned (rsp_error=1).
  - Otherwise go to ACCESS.
- ACCESS (one cycle): drive mem_access_addr from the latched addr with mem_read=1.
  - Load: lane = mem_read_data >> (8*addr[2:0]). Truncate to the access size, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1). Register the result into rsp_rdata and go to RESP.
  - SD: mem_write_data=wdata and mem_write_en=1 this cycle; go to RESP.
  - SB/SH/SW: mask = size-ones << (8*addr[2:0]). merged = (mem_read_data & ~mask) | ((wdata << (8*addr[2:0])) & mask). Register merged and go to WRITE.
- WRITE (one cycle): same mem_access_addr, mem_write_data=merged, mem_write_en=1, mem_read=0; go to RESP.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_error held stable.
  - When rsp_ready=1, go to IDLE and clear rsp_error.
  - A new request is not accepted in the same cycle as the response handshake.
- Latency from request accept to rsp_valid: load 2 cycles; SD 2 cycles; SB/SH/SW 3 cycles; misaligned 1 cycle.
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely, with no further memory activity.
- mem_write_en is asserted in at most one cycle per store and never during a load or an error.
- Upper address bits above MEM_ADDR_W+2 are ignored; the index wraps.

Test Plan:
- SD addr=0x10, wdata=0x8877665544332211, then LD addr=0x10 -> mem word 2 written once; rsp_rdata=0x8877665544332211; each rsp_valid arrives 2 cycles after accept.
- After the above, LB addr=0x17 -> 0xFFFFFFFFFFFFFF88; LBU addr=0x17 -> 0x88; LH addr=0x12 -> 0x4433; LW addr=0x14 -> 0xFFFFFFFF88776655; LWU addr=0x14 -> 0x88776655.
- SB addr=0x11, wdata=0xAB, then LD addr=0x10 -> 0x887766554433AB11. Store rsp_valid 3 cycles after accept; exactly one mem_write_en pulse, in the WRITE cycle.
- LW addr=0x12 and SH addr=0x13 -> rsp_error=1 one cycle after accept; mem_write_en never asserts; memory unchanged.
- Load with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; handshake completes and req_ready=1 the next cycle.
- Assert reset during the WRITE cycle of SW addr=0x18 -> mem_write_en drops immediately; word 3 unchanged; req_ready=1 and rsp_valid=0 after reset.

Source files
------------

// File: rtl/load_store_unit.sv
// RV64 load/store unit: byte-addressed loads and stores mapped onto a 64-bit,
// whole-word-write data memory, with read-merge-write for sub-doubleword stores.
module load_store_unit #(
   parameter int ADDR_W     = 64,
   parameter int MEM_ADDR_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [63:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [63:0]           rsp_rdata,
   output logic                  rsp_error,
   output logic [MEM_ADDR_W-1:0] mem_access_addr,
   output logic [63:0]           mem_write_data,
   output logic                  mem_write_en,
   output logic                  mem_read,
   input  logic [63:0]           mem_read_data
);

   localparam int LA_W = MEM_ADDR_W + 3;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_e;

   state_e            state_q, state_d;
   logic              error_q, error_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [LA_W-1:0]   addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [63:0]       rdata_q, rdata_d;
   logic [63:0]       merged_q, merged_d;
   logic              unused_addr_hi;

   // Address bits above the doubleword index are ignored, so the index wraps.
   assign unused_addr_hi = ^req_addr[ADDR_W-1:LA_W];

   function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                       input logic [2:0] off);
      logic bad;
      bad = is_store ? f3[2] : (f3 == 3'b111);
      case (f3[1:0])
         2'd0:    bad = bad;
         2'd1:    bad = bad | off[0];
         2'd2:    bad = bad | (|off[1:0]);
         default: bad = bad | (|off[2:0]);
      endcase
      return bad;
   endfunction

   function automatic logic [63:0] load_extend(input logic [63:0] dw, input logic [2:0] f3,
                                               input logic [2:0] off);
      logic [63:0] lane;
      logic [63:0] res;
      lane = dw >> {off, 3'b000};
      case (f3)
         3'b000:  res = {{56{lane[7]}},  lane[7:0]};
         3'b001:  res = {{48{lane[15]}}, lane[15:0]};
         3'b010:  res = {{32{lane[31]}}, lane[31:0]};
         3'b011:  res = lane;
         3'b100:  res = {56'd0, lane[7:0]};
         3'b101:  res = {48'd0, lane[15:0]};
         3'b110:  res = {32'd0, lane[31:0]};
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   function automatic logic [63:0] store_merge(input logic [63:0] dw, input logic [63:0] wd,
                                               input logic [1:0] sz, input logic [2:0] off);
      logic [63:0] mask;
      case (sz)
         2'd0:    mask = 64'h0000_0000_0000_00FF;
         2'd1:    mask = 64'h0000_0000_0000_FFFF;
         default: mask = 64'h0000_0000_FFFF_FFFF;
      endcase
      mask = mask << {off, 3'b000};
      return (dw & ~mask) | ((wd << {off, 3'b000}) & mask);
   endfunction

   always_comb begin
      state_d    = state_q;
      error_d    = error_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      merged_d   = merged_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               is_store_d = req_is_store;
               funct3_d   = req_funct3;
               addr_d     = req_addr[LA_W-1:0];
               wdata_d    = req_wdata;
               rdata_d    = 64'd0;
               error_d    = misaligned(req_is_store, req_funct3, req_addr[2:0]);
               state_d    = error_d ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!is_store_q) begin
               rdata_d = load_extend(mem_read_data, funct3_q, addr_q[2:0]);
               state_d = S_RESP;
            end else if (funct3_q[1:0] == 2'd3) begin
               state_d = S_RESP;
            end else begin
               merged_d = store_merge(mem_read_data, wdata_q, funct3_q[1:0], addr_q[2:0]);
               state_d  = S_WRITE;
            end
         end
         S_WRITE: state_d = S_RESP;
         default: begin
            if (rsp_ready) begin
               error_d = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         error_q <= error_d;
      end
   end

   // Operand and result registers carry no reset; every output they feed is
   // gated by state, so they are invisible while idle.
   always_ff @(posedge clk) begin
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      merged_q   <= merged_d;
   end

   assign req_ready       = (state_q == S_IDLE);
   assign rsp_valid       = (state_q == S_RESP);
   assign rsp_error       = error_q;
   assign rsp_rdata       = (state_q == S_RESP) ? rdata_q : 64'd0;
   assign mem_read        = (state_q == S_ACCESS);
   assign mem_access_addr = (state_q == S_ACCESS || state_q == S_WRITE) ?
                            addr_q[LA_W-1:3] : '0;
   // Write strobe decoded from state so a reset drops a pending write at once.
   assign mem_write_en    = (state_q == S_WRITE) ||
                            (state_q == S_ACCESS && is_store_q && funct3_q[1:0] == 2'd3);
   assign mem_write_data  = (state_q == S_WRITE) ? merged_q :
                            (mem_write_en ? wdata_q : 64'd0);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level memory model predicts each
// response, and a negedge monitor compares whatever the DUT returns.
module tb_load_store_unit;
   localparam int AW = 64;
   localparam int MW = 16;
   localparam int NBYTES = 1 << (MW + 3);

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_is_store;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [63:0]   req_wdata;
   logic          rsp_valid, rsp_ready, rsp_error;
   logic [63:0]   rsp_rdata;
   logic [MW-1:0] mem_access_addr;
   logic [63:0]   mem_write_data, mem_read_data;
   logic          mem_write_en, mem_read;

   load_store_unit #(.ADDR_W(AW), .MEM_ADDR_W(MW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .mem_access_addr(mem_access_addr),
      .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
      .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   logic [63:0] ram [0:(1<<MW)-1];
   logic [7:0]  ref_b [0:NBYTES-1];
   assign mem_read_data = ram[mem_access_addr];
   always @(posedge clk) if (mem_write_en) ram[mem_access_addr] <= mem_write_data;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          writes;
      int          acc_cyc;
      int          wr_snap;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0, failures = 0;
   int   cyc = 0, wr_total = 0, last_wr_cyc = -1;
   bit   head_seen = 0;
   int   bp_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%016h required=0x%016h", nm, act, exp);
      end
   endtask

   // Reference model: byte-addressed memory, plain arithmetic.
   function automatic int size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit ref_err(input bit st, input logic [2:0] f3, input logic [63:0] a);
      if (st && f3[2]) return 1'b1;
      if (!st && f3 == 3'b111) return 1'b1;
      return (a % size_of(f3)) != 0;
   endfunction

   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
      int n, b;
      logic [63:0] v;
      n = size_of(f3);
      b = int'(a % NBYTES);
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_b[b+i]) << (8*i));
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      int b;
      b = int'(a % NBYTES);
      for (int i = 0; i < size_of(f3); i++) ref_b[b+i] = 8'(wd >> (8*i));
   endtask

   function automatic logic [63:0] ref_word(input int idx);
      logic [63:0] v;
      v = 64'd0;
      for (int j = 0; j < 8; j++) v = v | (64'(ref_b[idx*8+j]) << (8*j));
      return v;
   endfunction

   task automatic issue(input bit st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input bit push);
      exp_t e;
      bit ok;
      ok = 1'b0;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = wd;
      req_valid    = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         check("accept_timeout", {63'd0, req_ready}, 64'd1);
         req_valid = 1'b0;
         return;
      end
      if (push) begin
         e.err     = ref_err(st, f3, a);
         e.rdata   = (e.err || st) ? 64'd0 : ref_load(f3, a);
         e.lat     = e.err ? 1 : ((st && f3[1:0] != 2'd3) ? 3 : 2);
         e.writes  = (st && !e.err) ? 1 : 0;
         e.acc_cyc = cyc;
         e.wr_snap = wr_total;
         if (st && !e.err) ref_store(f3, a, wd);
         sbq.push_back(e);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 500 && sbq.size() != 0; k++) @(negedge clk);
      check("drain", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 2) != 0);
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every response handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_write_en) begin wr_total++; last_wr_cyc = cyc; end
         if (!reset && rsp_valid) begin
            if (sbq.size() == 0) begin
               check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
               if (!head_seen) begin
                  head_seen = 1'b1;
                  check("rsp_latency", 64'(cyc), 64'(sbq[0].acc_cyc + sbq[0].lat));
               end
               check("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
               if (rsp_ready) begin
                  e = sbq.pop_front();
                  head_seen = 1'b0;
                  check("rsp_rdata", rsp_rdata, e.rdata);
                  check("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
                  check("write_pulses", 64'(wr_total - e.wr_snap), 64'(e.writes));
                  if (e.writes == 1)
                     check("write_cycle", 64'(last_wr_cyc), 64'(e.acc_cyc + e.lat - 1));
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout actual=%0d required=<%0d", cyc, cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] a, wd, expv, w3;
      logic [2:0]  f3;
      bit          st;
      int          bad;
      reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
      req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < (1 << MW); i++) begin
         ram[i] = {$urandom, $urandom};
         for (int j = 0; j < 8; j++) ref_b[i*8+j] = ram[i][8*j +: 8];
      end
      repeat (2) @(negedge clk);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_mem_we", {63'd0, mem_write_en}, 64'd0);
      check("rst_mem_read", {63'd0, mem_read}, 64'd0);
      check("rst_mem_addr", 64'(mem_access_addr), 64'd0);
      check("rst_mem_wdata", mem_write_data, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed sequence
      issue(1, 3'b011, 64'h10, 64'h8877665544332211, 1);
      issue(0, 3'b011, 64'h10, 64'd0, 1);
      issue(0, 3'b000, 64'h17, 64'd0, 1);
      issue(0, 3'b100, 64'h17, 64'd0, 1);
      issue(0, 3'b001, 64'h12, 64'd0, 1);
      issue(0, 3'b010, 64'h14, 64'd0, 1);
      issue(0, 3'b110, 64'h14, 64'd0, 1);
      issue(1, 3'b000, 64'h11, 64'hAB, 1);
      issue(0, 3'b011, 64'h10, 64'd0, 1);
      issue(0, 3'b010, 64'h12, 64'd0, 1);
      issue(1, 3'b001, 64'h13, 64'hFFFF, 1);
      issue(0, 3'b111, 64'h10, 64'd0, 1);
      issue(1, 3'b100, 64'h10, 64'd0, 1);
      issue(0, 3'b011, 64'hABCD_0000_0000_0010, 64'd0, 1);
      wait_drain();
      check("word2_after_sb", ram[2], 64'h887766554433AB11);

      // Randomized traffic with random backpressure
      bp_mode = 1;
      for (int n = 0; n < 300; n++) begin
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a[63:19] = '0;
         a[18:0] = 19'($urandom_range(0, 127));
         if ($urandom_range(0, 1) != 0) a = a & ~64'(size_of(f3) - 1);
         wd = {$urandom, $urandom};
         issue(st, f3, a, wd, 1);
      end
      wait_drain();

      // Backpressure held for 5 cycles
      bp_mode = 2;
      @(posedge clk); #2;
      expv = ref_load(3'b011, 64'h10);
      issue(0, 3'b011, 64'h10, 64'd0, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      for (int k = 0; k < 5; k++) begin
         check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check("bp_rsp_rdata", rsp_rdata, expv);
         check("bp_req_ready", {63'd0, req_ready}, 64'd0);
         @(negedge clk);
      end
      bp_mode = 0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check("bp_req_ready_after", {63'd0, req_ready}, 64'd1);
      check("bp_rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
      wait_drain();

      // Reset during the WRITE cycle of SW 0x18
      w3 = ref_word(3);
      @(posedge clk); #1;
      issue(1, 3'b010, 64'h18, ~w3, 0);
      @(posedge clk); #1;
      check("sw_write_cycle_we", {63'd0, mem_write_en}, 64'd1);
      reset = 1'b1;
      #1;
      check("rst_drop_we", {63'd0, mem_write_en}, 64'd0);
      check("rst_req_ready_mid", {63'd0, req_ready}, 64'd1);
      check("rst_rsp_valid_mid", {63'd0, rsp_valid}, 64'd0);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      check("word3_unchanged", ram[3], w3);
      @(negedge clk);
      check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);

      bad = 0;
      for (int i = 0; i < (1 << MW); i++) if (ram[i] !== ref_word(i)) bad++;
      check("mem_image", 64'(bad), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
